// File: rtl/muldiv_unit.sv
// Multiply/divide unit: pipelined MULT/MULTU with MUL_STAGES latency and an
// iterative restoring divider (one quotient bit per cycle) for DIV/DIVU.
//
// Handshake: a request is accepted on a rising edge where start_valid and
// start_ready are both high; start_ready is high only in IDLE without flush.
// The result appears as a single-cycle res_valid strobe (DONE state); all
// result fields read as zero whenever res_valid is low.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            res_valid,
    output logic            res_we,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo,
    output logic            div_zero,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW      = $clog2(XLEN + 1);
    // Product registers between operand capture and DONE; one stage fewer
    // than MUL_STAGES because the operand capture itself is the first cycle.
    localparam int PIPE    = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int OUT_IDX = PIPE - 1;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                dz_q, dz_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [2*XLEN-1:0]   prod_q [PIPE];
    logic [2*XLEN-1:0]   prod_d [PIPE];

    logic [2*XLEN-1:0]   ext_a, ext_b, prod_now, prod_out;
    logic                in_signed, a_neg_in, b_neg_in;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       rem_sh, trial;
    logic                trial_ok;
    logic [XLEN-1:0]     div_hi, div_lo;
    logic [XLEN-1:0]     hi_sel, lo_sel;

    assign start_ready = (state_q == IDLE) && !flush;
    assign busy        = (state_q != IDLE);
    assign dbg_state   = state_q;

    // Multiplier datapath works on the captured operands only.
    assign ext_a    = {{XLEN{~op_q[0] & a_q[XLEN-1]}}, a_q};
    assign ext_b    = {{XLEN{~op_q[0] & b_q[XLEN-1]}}, b_q};
    assign prod_now = ext_a * ext_b;
    assign prod_out = (MUL_STAGES == 1) ? prod_now : prod_q[OUT_IDX];

    // Divider operands are reduced to magnitudes at accept time.
    assign in_signed = ~op[0];
    assign a_neg_in  = in_signed & src_a[XLEN-1];
    assign b_neg_in  = in_signed & src_b[XLEN-1];
    assign a_mag     = a_neg_in ? -src_a : src_a;
    assign b_mag     = b_neg_in ? -src_b : src_b;

    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign trial_ok = ~trial[XLEN];

    // Most-negative / -1 falls out naturally: magnitude quotient 2^(XLEN-1)
    // with a positive sign wraps back to the most-negative pattern.
    assign div_lo = qneg_q ? -quo_q : quo_q;
    assign div_hi = rneg_q ? -rem_q : rem_q;

    always_comb begin
        hi_sel = '0;
        lo_sel = '0;
        if (!op_q[1]) begin
            hi_sel = prod_out[2*XLEN-1:XLEN];
            lo_sel = prod_out[XLEN-1:0];
        end else if (dz_q) begin
            hi_sel = a_q;
            lo_sel = '1;
        end else begin
            hi_sel = div_hi;
            lo_sel = div_lo;
        end
    end

    always_comb begin
        res_valid = (state_q == DONE) && !flush;
        res_we    = res_valid && !dz_q;
        div_zero  = res_valid && dz_q;
        res_hi    = res_valid ? hi_sel : '0;
        res_lo    = res_valid ? lo_sel : '0;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        prod_d[0] = prod_now;
        for (int i = 1; i < PIPE; i++) begin
            prod_d[i] = prod_q[i-1];
        end

        unique case (state_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    op_d  = op;
                    a_d   = src_a;
                    b_d   = src_b;
                    dz_d  = 1'b0;
                    cnt_d = '0;
                    if (!op[1]) begin
                        state_d = (MUL_STAGES == 1) ? DONE : MUL;
                    end else if (src_b == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = a_mag;
                        rem_d   = '0;
                        dvs_d   = b_mag;
                        qneg_d  = a_neg_in ^ b_neg_in;
                        rneg_d  = a_neg_in;
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MUL_STAGES - 2)) begin
                    state_d = DONE;
                end
            end
            DIV: begin
                rem_d = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], trial_ok};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            for (int i = 0; i < PIPE; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            for (int i = 0; i < PIPE; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, MUL_STAGES=2): vector table plus
// hand-written flush and reset sequences.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start_valid;
  logic            start_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            busy;
  logic            res_valid;
  logic            res_we;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;
  logic            div_zero;
  logic [1:0]      dbg_state;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy),
    .res_valid(res_valid), .res_we(res_we), .res_hi(res_hi), .res_lo(res_lo),
    .div_zero(div_zero), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // scoreboard: {res_we, div_zero, res_hi, res_lo}
  logic [65:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int id, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s id=%0d act=%h exp=%h", name, id, act, exp);
    end
  endtask

  // driver: one request, then watch for its result with a bounded wait
  task automatic run_op(input vec_t v, input int id);
    int k;
    int first;
    bit seen;
    bit busy_ok;
    bit quiet_ok;
    logic [65:0] exp;
    logic [65:0] act;
    k = 0;
    while (!start_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ready_before", id, {65'd0, start_ready}, 66'd1);
    exp_q.push_back({v.we, v.dz, v.hi, v.lo});
    start_valid = 1'b1;
    op = v.op;
    src_a = v.a;
    src_b = v.b;
    @(posedge clk);
    #1;
    // keep requesting with garbage while busy: must be ignored and not disturb capture
    op = 2'($urandom_range(0, 3));
    src_a = $urandom;
    src_b = $urandom;
    seen = 0;
    first = 0;
    busy_ok = 1;
    quiet_ok = 1;
    act = '0;
    for (int c = 1; c <= v.lat + 4 && !seen; c++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1;
        first = c;
        act = {res_we, div_zero, res_hi, res_lo};
        start_valid = 1'b0;
      end else begin
        if (!busy || start_ready) busy_ok = 0;
        if (res_we || div_zero || res_hi != 0 || res_lo != 0) quiet_ok = 0;
      end
    end
    start_valid = 1'b0;
    exp = exp_q.pop_front();
    check("latency", id, 66'(first), 66'(v.lat));
    check("result", id, act, exp);
    check("busy_hold", id, {65'd0, busy_ok}, 66'd1);
    check("quiet_out", id, {65'd0, quiet_ok}, 66'd1);
    @(negedge clk);
    check("one_shot", id, {64'd0, res_valid, start_ready}, 66'b01);
  endtask

  task automatic watch_silent(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (res_valid) hits++;
    end
    check(name, 0, 66'(hits), 66'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b0, 2};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0, 2};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0, 33};
    vecs[3]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b1, 1};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 33};
    vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b1, 1'b0, 33};
    vecs[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b1, 1'b0, 33};
    vecs[7]  = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b1, 1'b0, 2};
    vecs[8]  = '{2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 33};
    vecs[10] = '{2'b01, 32'd6,        32'd7,        32'd0,        32'd42,       1'b1, 1'b0, 2};
    vecs[11] = '{2'b10, 32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0, 33};

    rst = 1'b1;
    start_valid = 1'b0;
    op = 2'b00;
    src_a = '0;
    src_b = '0;
    flush = 1'b0;
    #1;
    check("reset_out", 0, {res_valid, res_we, div_zero, busy, res_hi, res_lo}, 66'd0);
    check("reset_ready", 0, {64'd0, start_ready, busy}, 66'b10);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], i);
    end

    // flush on the 10th cycle of a DIV, with a competing request
    start_valid = 1'b1;
    op = 2'b11;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    start_valid = 1'b1;
    op = 2'b01;
    src_a = 32'd3;
    src_b = 32'd3;
    #1;
    check("flush_ready", 100, {64'd0, start_ready, res_valid}, 66'b00);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", 100, {64'd0, busy, start_ready}, 66'b01);
    watch_silent("flush_silent", 40);

    // flush in the same cycle as the DONE strobe
    start_valid = 1'b1;
    op = 2'b11;
    src_a = 32'h55;
    src_b = 32'h0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_done", 101, {res_valid, res_we, div_zero, 1'b0, res_hi, res_lo}, 66'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 101, {64'd0, busy, start_ready}, 66'b01);
    watch_silent("flush_done_silent", 5);

    // asynchronous reset in the middle of a MULT
    start_valid = 1'b1;
    op = 2'b00;
    src_a = 32'd5;
    src_b = 32'd5;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_out", 102, {res_valid, res_we, div_zero, busy, res_hi, res_lo}, 66'd0);
    check("rst_mid_ready", 102, {65'd0, start_ready}, 66'd1);
    @(negedge clk);
    rst = 1'b0;
    watch_silent("rst_silent", 5);
    run_op(vecs[10], 103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
